axi_lite_sram_slave: RTL and testbench

- AXI-lite subordinate (responder) that serves the LSU's AXI-lite master port from an internal word-addressed SRAM array.
- Read and write channels run independent FSMs with configurable response latency, so the LSU's multi-cycle load/store handshakes can be exercised.
- Supports byte-strobe writes and DECERR for out-of-range addresses.
- Sits between the LSU (or an arbiter) and the data memory model.

---
 rtl/axi_lite_sram_slave.sv | 217 +++++++++++++++++++++
 tb/tb_axi_lite_sram_slave.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_sram_slave.sv
// axi_lite_sram_slave
//   AXI-lite responder backed by a word-addressed SRAM array. The read and
//   write channels run independent FSMs. Each has a programmable response
//   latency so that multi-cycle master handshakes can be exercised. Writes
//   honour byte strobes. Addresses outside [BASE, BASE + DEPTH*bytes) get
//   DECERR and never touch the array.
//
// Ports
//   clk_i, rst_i            clock (rising edge), async active-high reset
//   slv_ar_*                read address channel (valid/addr in, ready out)
//   slv_r_*                 read data channel (valid/data/resp out, ready in)
//   slv_aw_*                write address channel
//   slv_w_*                 write data channel with byte strobes
//   slv_b_*                 write response channel
module axi_lite_sram_slave #(
    parameter int unsigned       ADDR_W = 32,
    parameter int unsigned       DATA_W = 32,
    parameter int unsigned       DEPTH  = 1024,
    parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000,
    parameter int unsigned       RD_LAT = 2,
    parameter int unsigned       WR_LAT = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  slv_ar_valid_i,
    input  logic [ADDR_W-1:0]     slv_ar_addr_i,
    output logic                  slv_ar_ready_o,
    output logic                  slv_r_valid_o,
    output logic [DATA_W-1:0]     slv_r_data_o,
    output logic [1:0]            slv_r_resp_o,
    input  logic                  slv_r_ready_i,

    input  logic                  slv_aw_valid_i,
    input  logic [ADDR_W-1:0]     slv_aw_addr_i,
    output logic                  slv_aw_ready_o,
    input  logic                  slv_w_valid_i,
    input  logic [DATA_W-1:0]     slv_w_data_i,
    input  logic [DATA_W/8-1:0]   slv_w_strb_i,
    output logic                  slv_w_ready_o,
    output logic                  slv_b_valid_o,
    output logic [1:0]            slv_b_resp_o,
    input  logic                  slv_b_ready_i
);

    localparam int unsigned       STRB_W = DATA_W / 8;
    localparam int unsigned       OFF_W  = $clog2(STRB_W);
    localparam int unsigned       IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] SPAN   = ADDR_W'(DEPTH * STRB_W);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_RESP = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_WAIT = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a >= BASE) && ((a - BASE) < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE) >> OFF_W);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    // Low for the first clock after reset release so no handshake can land
    // on the edge that ends reset.
    logic reset_done;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) reset_done <= 1'b0;
        else       reset_done <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr_q;

    assign slv_ar_ready_o = reset_done && (r_state == R_IDLE);
    assign slv_r_valid_o  = (r_state == R_RESP);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= R_IDLE;
            r_cnt        <= '0;
            r_addr_q     <= '0;
            slv_r_data_o <= '0;
            slv_r_resp_o <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (slv_ar_valid_i && slv_ar_ready_o) begin
                        r_addr_q <= slv_ar_addr_i;
                        r_cnt    <= 4'(RD_LAT);
                        r_state  <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_cnt == '0) begin
                        if (addr_ok(r_addr_q)) begin
                            slv_r_data_o <= mem[addr_idx(r_addr_q)];
                            slv_r_resp_o <= RESP_OKAY;
                        end else begin
                            slv_r_data_o <= '0;
                            slv_r_resp_o <= RESP_DECERR;
                        end
                        r_state <= R_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                R_RESP: begin
                    if (slv_r_ready_i) r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    logic [1:0]        w_state;
    logic [3:0]        w_cnt;
    logic              aw_got;
    logic              w_got;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;

    logic              aw_fire;
    logic              w_fire;
    logic              commit;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_data;
    logic [STRB_W-1:0] c_strb;

    assign slv_aw_ready_o = reset_done && (w_state == W_IDLE) && !aw_got;
    assign slv_w_ready_o  = reset_done && (w_state == W_IDLE) && !w_got;
    assign slv_b_valid_o  = (w_state == W_RESP);

    assign aw_fire = slv_aw_valid_i && slv_aw_ready_o;
    assign w_fire  = slv_w_valid_i && slv_w_ready_o;

    // Commit as soon as both halves are available, taking each half either
    // from its holding register or straight off the bus in the handshake
    // cycle; this covers AW-first, W-first and same-cycle arrival alike.
    always_comb begin
        commit = (w_state == W_IDLE) && (aw_got || aw_fire) && (w_got || w_fire);
        c_addr = aw_got ? aw_addr_q : slv_aw_addr_i;
        c_data = w_got  ? w_data_q  : slv_w_data_i;
        c_strb = w_got  ? w_strb_q  : slv_w_strb_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_state      <= W_IDLE;
            w_cnt        <= '0;
            aw_got       <= 1'b0;
            w_got        <= 1'b0;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            slv_b_resp_o <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (commit) begin
                        aw_got       <= 1'b0;
                        w_got        <= 1'b0;
                        slv_b_resp_o <= addr_ok(c_addr) ? RESP_OKAY : RESP_DECERR;
                        w_cnt        <= 4'(WR_LAT);
                        w_state      <= W_WAIT;
                    end else begin
                        if (aw_fire) begin
                            aw_got    <= 1'b1;
                            aw_addr_q <= slv_aw_addr_i;
                        end
                        if (w_fire) begin
                            w_got    <= 1'b1;
                            w_data_q <= slv_w_data_i;
                            w_strb_q <= slv_w_strb_i;
                        end
                    end
                end
                W_WAIT: begin
                    if (w_cnt == '0) w_state <= W_RESP;
                    else             w_cnt   <= w_cnt - 4'd1;
                end
                W_RESP: begin
                    if (slv_b_ready_i) w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Array is never reset. commit is already low while rst_i is high
    // because the readies and capture flags are held clear.
    always_ff @(posedge clk_i) begin
        if (commit && addr_ok(c_addr)) begin
            for (int unsigned k = 0; k < STRB_W; k++) begin
                if (c_strb[k]) mem[addr_idx(c_addr)][8*k +: 8] <= c_data[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed bench for axi_lite_sram_slave with default parameters
// (DEPTH=1024, BASE=8000_0000, RD_LAT=2, WR_LAT=1).
module tb_axi_lite_sram_slave;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        slv_ar_valid_i = 1'b0;
    logic [31:0] slv_ar_addr_i  = '0;
    logic        slv_ar_ready_o;
    logic        slv_r_valid_o;
    logic [31:0] slv_r_data_o;
    logic [1:0]  slv_r_resp_o;
    logic        slv_r_ready_i  = 1'b0;
    logic        slv_aw_valid_i = 1'b0;
    logic [31:0] slv_aw_addr_i  = '0;
    logic        slv_aw_ready_o;
    logic        slv_w_valid_i  = 1'b0;
    logic [31:0] slv_w_data_i   = '0;
    logic [3:0]  slv_w_strb_i   = '0;
    logic        slv_w_ready_o;
    logic        slv_b_valid_o;
    logic [1:0]  slv_b_resp_o;
    logic        slv_b_ready_i  = 1'b0;

    int checks = 0;
    int errors = 0;

    axi_lite_sram_slave #(
        .ADDR_W (32),
        .DATA_W (32),
        .DEPTH  (1024),
        .BASE   (32'h8000_0000),
        .RD_LAT (2),
        .WR_LAT (1)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .slv_ar_valid_i (slv_ar_valid_i),
        .slv_ar_addr_i  (slv_ar_addr_i),
        .slv_ar_ready_o (slv_ar_ready_o),
        .slv_r_valid_o  (slv_r_valid_o),
        .slv_r_data_o   (slv_r_data_o),
        .slv_r_resp_o   (slv_r_resp_o),
        .slv_r_ready_i  (slv_r_ready_i),
        .slv_aw_valid_i (slv_aw_valid_i),
        .slv_aw_addr_i  (slv_aw_addr_i),
        .slv_aw_ready_o (slv_aw_ready_o),
        .slv_w_valid_i  (slv_w_valid_i),
        .slv_w_data_i   (slv_w_data_i),
        .slv_w_strb_i   (slv_w_strb_i),
        .slv_w_ready_o  (slv_w_ready_o),
        .slv_b_valid_o  (slv_b_valid_o),
        .slv_b_resp_o   (slv_b_resp_o),
        .slv_b_ready_i  (slv_b_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // AR handshake, then r_valid must appear on exactly the third edge after it.
    task automatic do_read(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_d, input logic [1:0] exp_r);
        slv_ar_valid_i = 1'b1;
        slv_ar_addr_i  = addr;
        chk({tag, "_arrdy"}, 64'(slv_ar_ready_o), 64'd1);
        tick();
        slv_ar_valid_i = 1'b0;
        chk({tag, "_arrdy_lo"}, 64'(slv_ar_ready_o), 64'd0);
        chk({tag, "_rv0"}, 64'(slv_r_valid_o), 64'd0);
        tick();
        chk({tag, "_rv1"}, 64'(slv_r_valid_o), 64'd0);
        tick();
        chk({tag, "_rv2"}, 64'(slv_r_valid_o), 64'd0);
        tick();
        chk({tag, "_rv3"}, 64'(slv_r_valid_o), 64'd1);
        chk({tag, "_rdata"}, 64'(slv_r_data_o), 64'(exp_d));
        chk({tag, "_rresp"}, 64'(slv_r_resp_o), 64'(exp_r));
        slv_r_ready_i = 1'b1;
        tick();
        slv_r_ready_i = 1'b0;
        chk({tag, "_rv_done"}, 64'(slv_r_valid_o), 64'd0);
        chk({tag, "_arrdy_back"}, 64'(slv_ar_ready_o), 64'd1);
    endtask

    // AW and W together; b_valid must appear two edges after the commit edge.
    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_r);
        slv_aw_valid_i = 1'b1;
        slv_aw_addr_i  = addr;
        slv_w_valid_i  = 1'b1;
        slv_w_data_i   = data;
        slv_w_strb_i   = strb;
        tick();
        slv_aw_valid_i = 1'b0;
        slv_w_valid_i  = 1'b0;
        chk({tag, "_rdy_lo"}, 64'({slv_aw_ready_o, slv_w_ready_o}), 64'd0);
        chk({tag, "_bv0"}, 64'(slv_b_valid_o), 64'd0);
        tick();
        chk({tag, "_bv1"}, 64'(slv_b_valid_o), 64'd0);
        tick();
        chk({tag, "_bv2"}, 64'(slv_b_valid_o), 64'd1);
        chk({tag, "_bresp"}, 64'(slv_b_resp_o), 64'(exp_r));
        slv_b_ready_i = 1'b1;
        tick();
        slv_b_ready_i = 1'b0;
        chk({tag, "_bv_done"}, 64'(slv_b_valid_o), 64'd0);
        chk({tag, "_rdy_back"}, 64'({slv_aw_ready_o, slv_w_ready_o}), 64'd3);
    endtask

    initial begin
        // ---------------- power-on reset ----------------
        rst_i = 1'b1;
        #1;
        chk("rst_readies", 64'({slv_ar_ready_o, slv_aw_ready_o, slv_w_ready_o}), 64'd0);
        chk("rst_valids", 64'({slv_r_valid_o, slv_b_valid_o}), 64'd0);
        chk("rst_rdata", 64'(slv_r_data_o), 64'd0);
        chk("rst_resps", 64'({slv_r_resp_o, slv_b_resp_o}), 64'd0);
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        chk("post_rst_hold", 64'({slv_ar_ready_o, slv_aw_ready_o, slv_w_ready_o}), 64'd0);
        tick();
        chk("post_rst_up", 64'({slv_ar_ready_o, slv_aw_ready_o, slv_w_ready_o}), 64'd7);

        // ---------------- 1: same-cycle write then read-back ----------------
        do_write("w1", 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00);
        do_read("r1", 32'h8000_0010, 32'hDEAD_BEEF, 2'b00);

        // ---------------- 2: W three cycles ahead of AW, partial strobes ----------------
        slv_w_valid_i = 1'b1;
        slv_w_data_i  = 32'h1122_3344;
        slv_w_strb_i  = 4'b0101;
        tick();
        slv_w_valid_i = 1'b0;
        chk("w2_wrdy_lo0", 64'(slv_w_ready_o), 64'd0);
        chk("w2_awrdy_hi", 64'(slv_aw_ready_o), 64'd1);
        tick();
        chk("w2_wrdy_lo1", 64'(slv_w_ready_o), 64'd0);
        tick();
        chk("w2_wrdy_lo2", 64'(slv_w_ready_o), 64'd0);
        chk("w2_bv_early", 64'(slv_b_valid_o), 64'd0);
        slv_aw_valid_i = 1'b1;
        slv_aw_addr_i  = 32'h8000_0010;
        tick();
        slv_aw_valid_i = 1'b0;
        chk("w2_rdy_lo", 64'({slv_aw_ready_o, slv_w_ready_o}), 64'd0);
        chk("w2_bv0", 64'(slv_b_valid_o), 64'd0);
        tick();
        chk("w2_bv1", 64'(slv_b_valid_o), 64'd0);
        tick();
        chk("w2_bv2", 64'(slv_b_valid_o), 64'd1);
        chk("w2_bresp", 64'(slv_b_resp_o), 64'd0);
        chk("w2_wrdy_resp", 64'(slv_w_ready_o), 64'd0);
        slv_b_ready_i = 1'b1;
        tick();
        slv_b_ready_i = 1'b0;
        chk("w2_rdy_back", 64'({slv_aw_ready_o, slv_w_ready_o}), 64'd3);
        do_read("r2", 32'h8000_0010, 32'hDE22_BE44, 2'b00);

        // ---------------- 3: out-of-range boundary ----------------
        do_write("w3a", 32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 2'b00);
        do_read("r3a", 32'h8000_0FFC, 32'hCAFE_F00D, 2'b00);
        do_read("r3oor", 32'h8000_1000, 32'h0000_0000, 2'b11);
        do_write("w3oor", 32'h8000_1000, 32'h1234_5678, 4'hF, 2'b11);
        do_read("r3b", 32'h8000_0FFC, 32'hCAFE_F00D, 2'b00);
        do_write("w3lo", 32'h7FFF_FFFC, 32'h1234_5678, 4'hF, 2'b11);
        do_write("w3s0", 32'h8000_0FFC, 32'hFFFF_FFFF, 4'h0, 2'b00);
        do_read("r3c", 32'h8000_0FFC, 32'hCAFE_F00D, 2'b00);

        // ---------------- 4: back-pressure ----------------
        slv_ar_valid_i = 1'b1;
        slv_ar_addr_i  = 32'h8000_0010;
        tick();
        slv_ar_valid_i = 1'b0;
        tick();
        tick();
        tick();
        chk("bp_rv", 64'(slv_r_valid_o), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_rv_hold", 64'(slv_r_valid_o), 64'd1);
            chk("bp_rdata_hold", 64'(slv_r_data_o), 64'h0000_0000_DE22_BE44);
            chk("bp_rresp_hold", 64'(slv_r_resp_o), 64'd0);
        end
        slv_r_ready_i = 1'b1;
        tick();
        slv_r_ready_i = 1'b0;
        chk("bp_rv_drop", 64'(slv_r_valid_o), 64'd0);
        chk("bp_arrdy", 64'(slv_ar_ready_o), 64'd1);
        tick();
        chk("bp_rv_single", 64'(slv_r_valid_o), 64'd0);

        slv_aw_valid_i = 1'b1;
        slv_aw_addr_i  = 32'h8000_2000;
        slv_w_valid_i  = 1'b1;
        slv_w_data_i   = 32'h0BAD_0BAD;
        slv_w_strb_i   = 4'hF;
        tick();
        slv_aw_valid_i = 1'b0;
        slv_w_valid_i  = 1'b0;
        tick();
        tick();
        chk("bp_bv", 64'(slv_b_valid_o), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_bv_hold", 64'(slv_b_valid_o), 64'd1);
            chk("bp_bresp_hold", 64'(slv_b_resp_o), 64'd3);
            chk("bp_rdy_hold", 64'({slv_aw_ready_o, slv_w_ready_o}), 64'd0);
        end
        slv_b_ready_i = 1'b1;
        tick();
        slv_b_ready_i = 1'b0;
        chk("bp_bv_drop", 64'(slv_b_valid_o), 64'd0);
        chk("bp_wrdys", 64'({slv_aw_ready_o, slv_w_ready_o}), 64'd3);
        tick();
        chk("bp_bv_single", 64'(slv_b_valid_o), 64'd0);

        // ---------------- 5: write committing on the read sample edge ----------------
        do_write("w5a", 32'h8000_0020, 32'hAAAA_5555, 4'hF, 2'b00);
        slv_ar_valid_i = 1'b1;
        slv_ar_addr_i  = 32'h8000_0020;
        tick();
        slv_ar_valid_i = 1'b0;
        tick();
        tick();
        slv_aw_valid_i = 1'b1;
        slv_aw_addr_i  = 32'h8000_0020;
        slv_w_valid_i  = 1'b1;
        slv_w_data_i   = 32'h5A5A_1234;
        slv_w_strb_i   = 4'hF;
        tick();
        slv_aw_valid_i = 1'b0;
        slv_w_valid_i  = 1'b0;
        chk("c5_rv", 64'(slv_r_valid_o), 64'd1);
        chk("c5_old", 64'(slv_r_data_o), 64'h0000_0000_AAAA_5555);
        slv_r_ready_i = 1'b1;
        tick();
        slv_r_ready_i = 1'b0;
        slv_b_ready_i = 1'b1;
        do_read("r5new", 32'h8000_0020, 32'h5A5A_1234, 2'b00);
        slv_b_ready_i = 1'b0;
        chk("c5_bdone", 64'(slv_b_valid_o), 64'd0);

        // ---------------- 6: async reset mid R_WAIT and mid W_RESP ----------------
        slv_aw_valid_i = 1'b1;
        slv_aw_addr_i  = 32'h8000_0030;
        slv_w_valid_i  = 1'b1;
        slv_w_data_i   = 32'h7777_7777;
        slv_w_strb_i   = 4'hF;
        tick();
        slv_aw_valid_i = 1'b0;
        slv_w_valid_i  = 1'b0;
        tick();
        tick();
        chk("ar_bv_pre", 64'(slv_b_valid_o), 64'd1);
        slv_ar_valid_i = 1'b1;
        slv_ar_addr_i  = 32'h8000_0010;
        tick();
        slv_ar_valid_i = 1'b0;
        chk("ar_rwait", 64'({slv_ar_ready_o, slv_r_valid_o}), 64'd0);
        #2;
        rst_i = 1'b1;
        #1;
        chk("ar_valids", 64'({slv_r_valid_o, slv_b_valid_o}), 64'd0);
        chk("ar_readies", 64'({slv_ar_ready_o, slv_aw_ready_o, slv_w_ready_o}), 64'd0);
        chk("ar_rdata", 64'(slv_r_data_o), 64'd0);
        @(posedge clk_i);
        #3;
        rst_i = 1'b0;
        #1;
        chk("ar_hold", 64'({slv_ar_ready_o, slv_aw_ready_o, slv_w_ready_o}), 64'd0);
        tick();
        chk("ar_up", 64'({slv_ar_ready_o, slv_aw_ready_o, slv_w_ready_o}), 64'd7);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ar_no_stale", 64'({slv_r_valid_o, slv_b_valid_o}), 64'd0);
        end
        do_read("r6a", 32'h8000_0010, 32'hDE22_BE44, 2'b00);
        do_read("r6b", 32'h8000_0030, 32'h7777_7777, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
